clk_sel_ctrl: RTL and testbench



---
 rtl/clk_sel_ctrl_pkg.sv | 21 ++
 rtl/settle_counter.sv | 32 +++
 rtl/clk_sel_ctrl.sv | 142 ++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_ctrl_pkg.sv
// Shared types and constants for the clock-select sequencer.
package clk_sel_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_OFF = 2'd1,
      WAIT_ON  = 2'd2,
      ACK      = 2'd3
   } state_t;

   // Safe post-reset mux configuration: source 0 selected and running.
   localparam logic RST_S   = 1'b0;
   localparam logic RST_CE0 = 1'b1;
   localparam logic RST_CE1 = 1'b0;

   // Width of a counter that must hold values up to and including settle.
   function automatic int cnt_width(input int settle);
      return $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with zero flag; times both settle phases of a switch.
module settle_counter
   import clk_sel_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int CW            = cnt_width(SETTLE_CYCLES)
) (
   input  logic CLK,
   input  logic RST,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

   logic [CW-1:0] count_q;

   // Load wins over decrement; decrement saturates at zero.
   always_ff @(posedge CLK) begin
      if (RST) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= RELOAD;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - CW'(1);
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/clk_sel_ctrl.sv
// Glitch-free select sequencer for a two-input clock mux: gate old source,
// settle, flip select, settle, enable new source.
// Optional feature macro: CLKSEL_LOCK_EN adds a LOCK input that blocks
// acceptance of new requests while high.
// Handshake: a request transfers on a rising edge where REQ_VALID and
// REQ_READY are both high; REQ_VALID must be held until then.
module clk_sel_ctrl
   import clk_sel_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8
) (
   input  logic CLK,
   input  logic RST,
   input  logic REQ_VALID,
   input  logic REQ_SEL,
`ifdef CLKSEL_LOCK_EN
   input  logic LOCK,
`endif
   output logic REQ_READY,
   output logic S,
   output logic CE0,
   output logic CE1,
   output logic BUSY,
   output logic DONE
);

   state_t state_q, state_d;
   logic   s_q, s_d;
   logic   ce0_q, ce0_d;
   logic   ce1_q, ce1_d;
   logic   busy_q, busy_d;
   logic   done_q, done_d;
   logic   ready_q, ready_d;
   logic   sel_q, sel_d;
   logic   cnt_load, cnt_dec, cnt_zero;
   logic   accept;

`ifdef CLKSEL_LOCK_EN
   assign REQ_READY = ready_q & ~LOCK;
`else
   assign REQ_READY = ready_q;
`endif

   assign accept = REQ_VALID && REQ_READY;

   settle_counter #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle (
      .CLK  (CLK),
      .RST  (RST),
      .load (cnt_load),
      .dec  (cnt_dec),
      .zero (cnt_zero)
   );

   // State and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         s_q     <= RST_S;
         ce0_q   <= RST_CE0;
         ce1_q   <= RST_CE1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         sel_q   <= RST_S;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         ce0_q   <= ce0_d;
         ce1_q   <= ce1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         sel_q   <= sel_d;
      end
   end

   // Next state and next registered output values.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      ce0_d    = ce0_q;
      ce1_d    = ce1_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ready_d  = ready_q;
      sel_d    = sel_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               ready_d = 1'b0;
               if (REQ_SEL == s_q) begin
                  done_d  = 1'b1;
                  state_d = ACK;
               end else begin
                  // Only the active source's enable can be high here.
                  if (s_q) ce1_d = 1'b0;
                  else     ce0_d = 1'b0;
                  sel_d    = REQ_SEL;
                  busy_d   = 1'b1;
                  cnt_load = 1'b1;
                  state_d  = WAIT_OFF;
               end
            end
         end
         WAIT_OFF: begin
            if (cnt_zero) begin
               s_d      = sel_q;
               cnt_load = 1'b1;
               state_d  = WAIT_ON;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         WAIT_ON: begin
            if (cnt_zero) begin
               ce0_d   = ~s_q;
               ce1_d   = s_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ACK: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign S    = s_q;
   assign CE0  = ce0_q;
   assign CE1  = ce1_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Self-checking bench for clk_sel_ctrl with SETTLE_CYCLES=4.
module tb_clk_sel_ctrl;

   localparam int SC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0;
   logic req_sel = 1'b0;
   logic lock = 1'b0;
   logic req_ready, s, ce0, ce1, busy, done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [0:0] exp_q[$];

   // clock / reset
   always #5 clk = ~clk;

   clk_sel_ctrl #(.SETTLE_CYCLES(SC)) dut (
      .CLK       (clk),
      .RST       (rst),
      .REQ_VALID (req_valid),
      .REQ_SEL   (req_sel),
`ifdef CLKSEL_LOCK_EN
      .LOCK      (lock),
`endif
      .REQ_READY (req_ready),
      .S         (s),
      .CE0       (ce0),
      .CE1       (ce1),
      .BUSY      (busy),
      .DONE      (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: outputs as a function of cycles elapsed since acceptance.
   logic m_valid = 1'b0;
   logic m_s, m_ce0, m_ce1, m_busy, m_done, m_ready;
   int   mode = 0;   // 0 none, 1 same-select, 2 switch
   int   m_t0 = 0;
   logic m_target, m_old;

   always @(posedge clk) begin
      int e;
      cyc++;
      if (rst) begin
         m_valid = 1'b1;
         m_s = 1'b0; m_ce0 = 1'b1; m_ce1 = 1'b0;
         m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b1;
         mode = 0;
      end else if (m_valid) begin
         if (mode == 0 && req_valid && m_ready && !lock) begin
            m_t0 = cyc;
            m_target = req_sel;
            m_old = m_s;
            mode = (req_sel == m_s) ? 1 : 2;
         end
         e = cyc - m_t0;
         if (mode == 1) begin
            if (e == 0) begin
               m_done = 1'b1; m_ready = 1'b0;
               exp_q.push_back(m_target);
            end else begin
               m_done = 1'b0; m_ready = 1'b1; mode = 0;
            end
         end else if (mode == 2) begin
            if (e < 2 * SC) begin
               m_busy = 1'b1; m_ready = 1'b0; m_done = 1'b0;
               m_ce0 = 1'b0; m_ce1 = 1'b0;
               m_s = (e >= SC) ? m_target : m_old;
            end else begin
               m_s = m_target; m_ce0 = ~m_target; m_ce1 = m_target;
               m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
               mode = 0;
               exp_q.push_back(m_target);
            end
         end else begin
            m_done = 1'b0;
         end
      end
   end

   // Compare process: every cycle once the model is initialised.
   always @(negedge clk) begin
      if (m_valid) begin
         check("s", s, m_s);
         check("ce0", ce0, m_ce0);
         check("ce1", ce1, m_ce1);
         check("busy", busy, m_busy);
         check("done", done, m_done);
         check("req_ready", req_ready, m_ready & ~lock);
         check("ce_exclusive", ce0 & ce1, 1'b0);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) check("done_unexpected", 1, 0);
            else check("done_sel", s, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_accept(input logic hold, output int t0);
      int n = 0;
      while (!req_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         check("accept_timeout", 1, 0);
         t0 = -1;
      end else begin
         t0 = cyc + 1;
      end
      tick();
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic send_req(input logic sel, input logic hold, output int t0);
      tick();
      req_valid = 1'b1;
      req_sel = sel;
      wait_accept(hold, t0);
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc < target && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) check("wait_timeout", 1, 0);
   endtask

   task automatic do_reset(input int n);
      tick();
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
   endtask

   initial begin
      int t0, t1;
      // reset and idle
      do_reset(2);
      check("rst_s", s, 0);
      check("rst_ce0", ce0, 1);
      check("rst_ce1", ce1, 0);
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);

      // same-select request
      send_req(1'b0, 1'b0, t0);
      check("same_done", done, 1);
      check("same_ready", req_ready, 0);
      check("same_busy", busy, 0);
      check("same_s", s, 0);
      check("same_ce0", ce0, 1);
      tick();
      check("same_done_end", done, 0);
      check("same_ready_end", req_ready, 1);

      // single switch 0 -> 1
      send_req(1'b1, 1'b0, t0);
      check("sw_ce0_off", ce0, 0);
      check("sw_busy", busy, 1);
      wait_cyc(t0 + SC - 1);
      check("sw_s_before", s, 0);
      wait_cyc(t0 + SC);
      check("sw_s_flip", s, 1);
      wait_cyc(t0 + 2 * SC - 1);
      check("sw_ce1_before", ce1, 0);
      check("sw_done_before", done, 0);
      wait_cyc(t0 + 2 * SC);
      check("sw_ce1_on", ce1, 1);
      check("sw_done", done, 1);
      check("sw_busy_end", busy, 0);
      tick();
      check("sw_done_once", done, 0);

      // same-select while S=1
      send_req(1'b1, 1'b0, t0);
      check("same1_done", done, 1);
      check("same1_ce1", ce1, 1);
      tick();

      // back-to-back from reset: 0 -> 1 -> 0
      do_reset(1);
      send_req(1'b1, 1'b1, t0);
      req_sel = 1'b0;
      wait_accept(1'b0, t1);
      check("b2b_gap", t1 - t0, 2 * SC + 1);
      wait_cyc(t1 + 2 * SC);
      check("b2b_s_final", s, 0);
      check("b2b_ce0_final", ce0, 1);
      tick();

      // reset mid-operation (in WAIT_ON)
      send_req(1'b1, 1'b0, t0);
      wait_cyc(t0 + SC + 1);
      check("mid_s_flipped", s, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_s", s, 0);
      check("mid_ce0", ce0, 1);
      check("mid_ce1", ce1, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      repeat (2 * SC) begin
         tick();
         check("mid_no_done", done, 0);
      end

`ifdef CLKSEL_LOCK_EN
      // lock blocks acceptance; release allows it on the next edge
      lock = 1'b1;
      req_valid = 1'b1;
      req_sel = 1'b1;
      tick();
      check("lock_ready", req_ready, 0);
      repeat (3) begin
         tick();
         check("lock_busy", busy, 0);
      end
      lock = 1'b0;
      t1 = cyc;
      wait_accept(1'b0, t0);
      check("lock_release", t0 - t1, 1);
      wait_cyc(t0 + 2 * SC + 1);
      check("lock_s", s, 1);
`endif

      tick();
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
